// File: rtl/e_mdu_if.sv
// Operation/operand bus between the E stage and the multiply/divide unit.
interface e_mdu_if;
  logic [3:0]  mdu_op;
  logic        start;
  logic [31:0] E_A;
  logic [31:0] E_B;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] E_MDU_result;

  modport master (
    output mdu_op, start, E_A, E_B,
    input  busy, hi, lo, E_MDU_result
  );

  modport slave (
    input  mdu_op, start, E_A, E_B,
    output busy, hi, lo, E_MDU_result
  );
endinterface

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: owns HI/LO and runs MULT/DIV ops with a fixed busy latency.
// The result is computed at the start edge and held in temp registers until the count expires.
module e_mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic   clk,
  input logic   reset,
  e_mdu_if.slave mdu
);

  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMthi  = 4'd5;
  localparam logic [3:0] OpMtlo  = 4'd6;
  localparam logic [3:0] OpMfhi  = 4'd7;
  localparam logic [3:0] OpMflo  = 4'd8;

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     hi_q, hi_d;
  logic [31:0]     lo_q, lo_d;
  logic [31:0]     temp_hi_q, temp_hi_d;
  logic [31:0]     temp_lo_q, temp_lo_d;
  logic            wb_en_q, wb_en_d;

  logic        is_mult, is_div;
  logic [63:0] mul_res;
  logic [31:0] abs_a, abs_b, mag_q, mag_r;
  logic [31:0] div_q, div_r;
  logic        neg_a, neg_b;

  assign is_mult = (mdu.mdu_op == OpMult) || (mdu.mdu_op == OpMultu);
  assign is_div  = (mdu.mdu_op == OpDiv)  || (mdu.mdu_op == OpDivu);

  // Operand datapath: signed ops go through magnitudes so INT_MIN / -1 wraps cleanly.
  always_comb begin
    neg_a   = (mdu.mdu_op == OpDiv) && mdu.E_A[31];
    neg_b   = (mdu.mdu_op == OpDiv) && mdu.E_B[31];
    abs_a   = neg_a ? (32'd0 - mdu.E_A) : mdu.E_A;
    abs_b   = neg_b ? (32'd0 - mdu.E_B) : mdu.E_B;
    mag_q   = 32'd0;
    mag_r   = 32'd0;
    if (abs_b != 32'd0) begin
      mag_q = abs_a / abs_b;
      mag_r = abs_a % abs_b;
    end
    div_q   = (neg_a ^ neg_b) ? (32'd0 - mag_q) : mag_q;
    div_r   = neg_a ? (32'd0 - mag_r) : mag_r;
    if (mdu.mdu_op == OpMult) begin
      mul_res = {{32{mdu.E_A[31]}}, mdu.E_A} * {{32{mdu.E_B[31]}}, mdu.E_B};
    end else begin
      mul_res = {32'd0, mdu.E_A} * {32'd0, mdu.E_B};
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    temp_hi_d = temp_hi_q;
    temp_lo_d = temp_lo_q;
    wb_en_d   = wb_en_q;
    unique case (state_q)
      StIdle: begin
        if (mdu.start && (is_mult || is_div)) begin
          state_d = StBusy;
          if (is_mult) begin
            cnt_d     = CntW'(MULT_CYCLES);
            temp_hi_d = mul_res[63:32];
            temp_lo_d = mul_res[31:0];
            wb_en_d   = 1'b1;
          end else begin
            cnt_d     = CntW'(DIV_CYCLES);
            temp_hi_d = div_r;
            temp_lo_d = div_q;
            // Divide by zero still burns the full latency but leaves HI/LO alone.
            wb_en_d   = (mdu.E_B != 32'd0);
          end
        end else if (mdu.mdu_op == OpMthi) begin
          hi_d = mdu.E_A;
        end else if (mdu.mdu_op == OpMtlo) begin
          lo_d = mdu.E_A;
        end
      end
      StBusy: begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StIdle;
          if (wb_en_q) begin
            hi_d = temp_hi_q;
            lo_d = temp_lo_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      temp_hi_q <= '0;
      temp_lo_q <= '0;
      wb_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      temp_hi_q <= temp_hi_d;
      temp_lo_q <= temp_lo_d;
      wb_en_q   <= wb_en_d;
    end
  end

  assign mdu.busy = (state_q == StBusy);
  assign mdu.hi   = hi_q;
  assign mdu.lo   = lo_q;

  always_comb begin
    case (mdu.mdu_op)
      OpMfhi:  mdu.E_MDU_result = hi_q;
      OpMflo:  mdu.E_MDU_result = lo_q;
      default: mdu.E_MDU_result = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_e_mdu.sv
// Bench for e_mdu: directed scenarios with literal expectations, then random traffic
// checked every cycle against an arithmetic model of HI/LO and the busy window.
module tb_e_mdu;

  localparam int MultN = 5;
  localparam int DivN  = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  e_mdu_if bus ();

  e_mdu #(
    .MULT_CYCLES (MultN),
    .DIV_CYCLES  (DivN)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .mdu   (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Model state.
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [31:0] p_hi = '0, p_lo = '0;
  bit          p_wb = 1'b0;
  int          m_left = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  always @(posedge clk) begin : model
    logic [31:0] a, b;
    longint      sa, sb, sp;
    longint unsigned up;
    a = bus.E_A;
    b = bus.E_B;
    if (!reset) begin
      m_hi = '0; m_lo = '0; p_hi = '0; p_lo = '0; p_wb = 1'b0; m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && p_wb) begin
        m_hi = p_hi;
        m_lo = p_lo;
      end
    end else if (bus.start && bus.mdu_op >= 4'd1 && bus.mdu_op <= 4'd4) begin
      p_wb = 1'b1;
      case (bus.mdu_op)
        4'd1: begin
          sp = longint'($signed(a)) * longint'($signed(b));
          p_hi = sp[63:32]; p_lo = sp[31:0]; m_left = MultN;
        end
        4'd2: begin
          up = longint'({32'd0, a}) * longint'({32'd0, b});
          p_hi = up[63:32]; p_lo = up[31:0]; m_left = MultN;
        end
        4'd3: begin
          m_left = DivN;
          if (b == 0) p_wb = 1'b0;
          else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            sp = sa / sb;
            p_lo = sp[31:0];
            sp = sa % sb;
            p_hi = sp[31:0];
          end
        end
        default: begin
          m_left = DivN;
          if (b == 0) p_wb = 1'b0;
          else begin
            p_lo = a / b;
            p_hi = a % b;
          end
        end
      endcase
    end else if (bus.mdu_op == 4'd5) begin
      m_hi = a;
    end else if (bus.mdu_op == 4'd6) begin
      m_lo = a;
    end
  end

  always @(negedge clk) begin : compare
    logic [31:0] want_res;
    if (cmp_en) begin
      want_res = (bus.mdu_op == 4'd7) ? m_hi : (bus.mdu_op == 4'd8) ? m_lo : 32'd0;
      chk("busy", {31'd0, bus.busy}, {31'd0, m_left > 0});
      chk("hi", bus.hi, m_hi);
      chk("lo", bus.lo, m_lo);
      chk("result", bus.E_MDU_result, want_res);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit st);
    bus.mdu_op = op;
    bus.E_A    = a;
    bus.E_B    = b;
    bus.start  = st;
    cyc(1);
    bus.mdu_op = 4'd0;
    bus.start  = 1'b0;
  endtask

  function automatic logic [31:0] rval();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'(int'($urandom_range(0, 20)) - 10);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset      = 1'b0;
    bus.mdu_op = 4'd0;
    bus.start  = 1'b0;
    bus.E_A    = '0;
    bus.E_B    = '0;
    cyc(2);
    cmp_en = 1'b1;
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    reset = 1'b1;
    cyc(1);

    // MULT -3 * 5
    issue(4'd1, 32'hFFFF_FFFD, 32'd5, 1'b1);
    chk("mult_busy_first", {31'd0, bus.busy}, 32'd1);
    cyc(4);
    chk("mult_busy_last", {31'd0, bus.busy}, 32'd1);
    cyc(1);
    chk("mult_busy_fall", {31'd0, bus.busy}, 32'd0);
    chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
    chk("mult_lo", bus.lo, 32'hFFFF_FFF1);
    chk("model_mult_lo", m_lo, 32'hFFFF_FFF1);

    // MULTU 0xFFFFFFFF * 2
    issue(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b1);
    cyc(5);
    chk("multu_hi", bus.hi, 32'h0000_0001);
    chk("multu_lo", bus.lo, 32'hFFFF_FFFE);

    // DIV -7 / 2, then DIVU 7 / 2 back-to-back
    issue(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b1);
    cyc(9);
    chk("div_busy_last", {31'd0, bus.busy}, 32'd1);
    cyc(1);
    chk("div_lo", bus.lo, 32'hFFFF_FFFD);
    chk("div_hi", bus.hi, 32'hFFFF_FFFF);
    issue(4'd4, 32'd7, 32'd2, 1'b1);
    cyc(10);
    chk("divu_lo", bus.lo, 32'd3);
    chk("divu_hi", bus.hi, 32'd1);

    // INT_MIN / -1
    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    cyc(10);
    chk("ovf_lo", bus.lo, 32'h8000_0000);
    chk("ovf_hi", bus.hi, 32'd0);
    chk("model_ovf_lo", m_lo, 32'h8000_0000);

    // MTHI then MFHI, then DIVU by zero
    issue(4'd5, 32'h1234_5678, 32'd0, 1'b0);
    bus.mdu_op = 4'd7;
    #1;
    chk("mfhi", bus.E_MDU_result, 32'h1234_5678);
    cyc(1);
    issue(4'd4, 32'd7, 32'd0, 1'b1);
    cyc(9);
    chk("dz_busy_last", {31'd0, bus.busy}, 32'd1);
    cyc(1);
    chk("dz_busy_fall", {31'd0, bus.busy}, 32'd0);
    chk("dz_hi", bus.hi, 32'h1234_5678);

    // MULT, then ignored DIV start one cycle later
    issue(4'd1, 32'd6, 32'd7, 1'b1);
    issue(4'd3, 32'd100, 32'd3, 1'b1);
    cyc(3);
    chk("ign_busy", {31'd0, bus.busy}, 32'd1);
    cyc(1);
    chk("ign_fall", {31'd0, bus.busy}, 32'd0);
    chk("ign_lo", bus.lo, 32'd42);
    chk("ign_hi", bus.hi, 32'd0);

    // Reset aborts a DIV in flight
    issue(4'd4, 32'd50, 32'd7, 1'b1);
    cyc(2);
    reset = 1'b0;
    cyc(1);
    reset = 1'b1;
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_lo", bus.lo, 32'd0);
    cyc(DivN + 2);
    chk("no_late_lo", bus.lo, 32'd0);
    chk("no_late_hi", bus.hi, 32'd0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      bus.mdu_op = 4'($urandom_range(0, 15));
      bus.start  = ($urandom_range(0, 3) == 0);
      bus.E_A    = rval();
      bus.E_B    = rval();
      reset      = ($urandom_range(0, 299) != 0);
      cyc(1);
    end
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.mdu_op = 4'd0;
    cyc(DivN + 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
